// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and FSM state type for the iterative multiply/divide unit.
// The divider datapath is built only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

   localparam int WIDTH = 32;
   localparam int ITER  = 32;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   localparam logic [WIDTH-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fixup.
module muldiv_negate #(
   parameter int WIDTH = muldiv_pkg::WIDTH
) (
   input  logic             en,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   assign out = en ? ((~in) + {{(WIDTH-1){1'b0}}, 1'b1}) : in;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 33-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise divide is a one-edge no-op.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = muldiv_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic             sign,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(ITER);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               res_sign;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] acc;

   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH-1:0]   acc_lo;
   logic [WIDTH-1:0]   lo_fix;
   logic [WIDTH-1:0]   hi_neg;
   logic [WIDTH-1:0]   hi_fix;
   logic               hi_neg_en;
   logic [WIDTH:0]     mul_sum;
   logic               op_sign;

   assign acc_hi  = acc[2*WIDTH-1:WIDTH];
   assign acc_lo  = acc[WIDTH-1:0];
   assign op_sign = sign & (in1[WIDTH-1] ^ in2[WIDTH-1]);

   // Shift-add step: acc holds {partial product, remaining multiplier bits}.
   assign mul_sum = {1'b0, acc_hi} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

   muldiv_negate #(.WIDTH(WIDTH)) u_neg_a  (.en(sign & in1[WIDTH-1]), .in(in1),    .out(mag_a));
   muldiv_negate #(.WIDTH(WIDTH)) u_neg_b  (.en(sign & in2[WIDTH-1]), .in(in2),    .out(mag_b));
   muldiv_negate #(.WIDTH(WIDTH)) u_neg_lo (.en(res_sign),            .in(acc_lo), .out(lo_fix));
   muldiv_negate #(.WIDTH(WIDTH)) u_neg_hi (.en(hi_neg_en),           .in(acc_hi), .out(hi_neg));

`ifdef MULDIV_DIV_EN
   logic               op_q;
   logic               rem_sign;
   logic               div0;
   logic [WIDTH:0]     partial;
   logic [WIDTH-1:0]   trial;
   logic               ge;

   // Restoring step: acc holds {remainder, dividend bits still to shift in / quotient}.
   assign partial = acc[2*WIDTH-1:WIDTH-1];
   assign ge      = partial >= {1'b0, mcand};
   assign trial   = partial[WIDTH-1:0] - mcand;

   assign hi_neg_en = (op_q == OP_DIV) ? rem_sign : res_sign;
   // A 2W-bit negate only carries into the upper half when the lower half is zero.
   assign hi_fix    = ((op_q == OP_MUL) && res_sign && (acc_lo != '0)) ? ~acc_hi : hi_neg;
`else
   assign hi_neg_en = res_sign;
   assign hi_fix    = (res_sign && (acc_lo != '0)) ? ~acc_hi : hi_neg;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         acc      <= '0;
         mcand    <= '0;
         res_sign <= 1'b0;
`ifdef MULDIV_DIV_EN
         op_q     <= OP_MUL;
         rem_sign <= 1'b0;
         div0     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
`ifdef MULDIV_DIV_EN
                  op_q     <= op;
                  rem_sign <= sign & in1[WIDTH-1];
                  div0     <= (in2 == '0);
                  res_sign <= op_sign;
                  state    <= CALC;
                  busy     <= 1'b1;
                  if (op == OP_DIV) begin
                     acc   <= {{WIDTH{1'b0}}, mag_a};
                     mcand <= mag_b;
                  end else begin
                     acc   <= {{WIDTH{1'b0}}, mag_b};
                     mcand <= mag_a;
                  end
`else
                  if (op == OP_DIV) begin
                     done <= 1'b1;
                  end else begin
                     acc      <= {{WIDTH{1'b0}}, mag_b};
                     mcand    <= mag_a;
                     res_sign <= op_sign;
                     state    <= CALC;
                     busy     <= 1'b1;
                  end
`endif
               end else begin
                  if (hi_we) hi <= wdata;
                  if (lo_we) lo <= wdata;
               end
            end

            CALC: begin
`ifdef MULDIV_DIV_EN
               if (op_q == OP_DIV)
                  acc <= {(ge ? trial : partial[WIDTH-1:0]), acc[WIDTH-2:0], ge};
               else
`endif
                  acc <= {mul_sum, acc[WIDTH-1:1]};
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(ITER-1)) begin
                  cnt   <= '0;
                  state <= FIX;
               end
            end

            FIX: begin
               hi    <= hi_fix;
`ifdef MULDIV_DIV_EN
               // Divide by zero keeps the raw all-ones quotient; the remainder fixup restores in1.
               lo    <= ((op_q == OP_DIV) && div0) ? WIDTH'(DIV0_QUOT) : lo_fix;
`else
               lo    <= lo_fix;
`endif
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
